// File: rtl/regfile_alu_pipe_if.sv
// regfile_alu_pipe_if: op issue, result and debug-read signals of regfile_alu_pipe.
//  master : op source and result sink (drives op fields and dbg_sel)
//  slave  : the datapath (drives in_ready, out_valid, alu_result, flags, dbg_data)
//  Signals:
//   in_valid/in_ready        op handshake, accepted on an edge where both are 1
//   opcode, rdest_sel,       op fields: ALU operation, dest/first operand register,
//   rsrc_sel, imm, imm_sel,  second operand register or immediate, writeback enable
//   wb_en
//   out_valid, alu_result,   one-cycle result pulse per op, {N,Z,F,L,C} flags
//   flags
//   dbg_sel, dbg_data        combinational register-file read port
interface regfile_alu_pipe_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [AW-1:0]    rdest_sel;
  logic [AW-1:0]    rsrc_sel;
  logic [WIDTH-1:0] imm;
  logic             imm_sel;
  logic             wb_en;
  logic             out_valid;
  logic [WIDTH-1:0] alu_result;
  logic [4:0]       flags;
  logic [AW-1:0]    dbg_sel;
  logic [WIDTH-1:0] dbg_data;

  modport master (
    output in_valid, opcode, rdest_sel, rsrc_sel, imm, imm_sel, wb_en, dbg_sel,
    input  in_ready, out_valid, alu_result, flags, dbg_data
  );

  modport slave (
    input  in_valid, opcode, rdest_sel, rsrc_sel, imm, imm_sel, wb_en, dbg_sel,
    output in_ready, out_valid, alu_result, flags, dbg_data
  );
endinterface

// File: rtl/regfile_alu_pipe.sv
// regfile_alu_pipe: two-stage pipelined datapath (register file, operand select, ALU,
// flags register, writeback). Accepts one op per cycle and resolves back-to-back RAW
// hazards against the op sitting in the execute stage.
//  Ports:
//   clk  clock, all state on rising edge
//   rst  asynchronous reset, active-high; clears registers, flags, outputs, E stage
//   bus  regfile_alu_pipe_if.slave (op handshake, result, flags, debug read)
//  Stages:
//   E : on accept, capture A=R[rdest_sel], B=imm_sel ? imm : R[rsrc_sel], op, dest, wb
//   W : next edge, ALU result registered to alu_result, flags update, optional writeback
//  Build option RF_FWD_EN:
//   defined   - hazard operands are forwarded from the ALU output, in_ready tied high
//   undefined - in_ready drops for one cycle on a hazard, the op then reads R directly
module regfile_alu_pipe #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              rst,
  regfile_alu_pipe_if.slave bus
);

  localparam int unsigned AW  = $clog2(NUM_REGS);
  localparam int unsigned SW  = $clog2(WIDTH);
  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_CMP = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_MOV = 4'd7;
  localparam logic [3:0] OP_LSH = 4'd8;
  localparam logic [3:0] OP_RSH = 4'd9;

  typedef struct packed {
    logic             valid;
    logic [3:0]       op;
    logic [AW-1:0]    dest;
    logic             wb;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } estage_t;

  // Opcodes whose result may be written back (CMP and NOP-class never write)
  function automatic logic op_writes(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV, OP_LSH, OP_RSH: op_writes = 1'b1;
      default:                                                      op_writes = 1'b0;
    endcase
  endfunction

  logic [WIDTH-1:0] regs [NUM_REGS];
  estage_t          e;

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic [4:0]       flags_q;

  logic [WIDTH:0]   sum_x;
  logic [WIDTH:0]   dif_x;
  logic [WIDTH-1:0] res;
  logic [4:0]       flags_nxt;
  logic             e_writes;

  logic             haz_a;
  logic             haz_b;
  logic             ready_c;
  logic             accept;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;

  // ALU on the E-stage operands; flags are {N,Z,F,L,C} and held unless ADD/SUB/CMP
  always_comb begin
    sum_x     = {1'b0, e.a} + {1'b0, e.b};
    dif_x     = {1'b0, e.a} - {1'b0, e.b};
    res       = '0;
    flags_nxt = flags_q;
    case (e.op)
      OP_ADD: begin
        res       = sum_x[WIDTH-1:0];
        flags_nxt = {res[MSB], ~|res,
                     (e.a[MSB] == e.b[MSB]) && (res[MSB] != e.a[MSB]),
                     1'b0, sum_x[WIDTH]};
      end
      OP_SUB, OP_CMP: begin
        // dif_x[WIDTH] is the borrow, i.e. unsigned A < B
        res       = dif_x[WIDTH-1:0];
        flags_nxt = {$signed(e.a) < $signed(e.b), ~|res,
                     (e.a[MSB] != e.b[MSB]) && (res[MSB] != e.a[MSB]),
                     dif_x[WIDTH], dif_x[WIDTH]};
      end
      OP_AND:  res = e.a & e.b;
      OP_OR:   res = e.a | e.b;
      OP_XOR:  res = e.a ^ e.b;
      OP_MOV:  res = e.b;
      OP_LSH:  res = e.a << e.b[SW-1:0];
      OP_RSH:  res = e.a >> e.b[SW-1:0];
      OP_NOP:  res = '0;
      default: res = '0;
    endcase
  end

  assign e_writes = e.valid && e.wb && op_writes(e.op);

  // Hazard detection against the E-stage op and operand fetch for the incoming op
  always_comb begin
    haz_a = e_writes && (bus.rdest_sel == e.dest);
    haz_b = e_writes && !bus.imm_sel && (bus.rsrc_sel == e.dest);
`ifdef RF_FWD_EN
    ready_c = 1'b1;
    opa     = haz_a ? res : regs[bus.rdest_sel];
    opb     = bus.imm_sel ? bus.imm : (haz_b ? res : regs[bus.rsrc_sel]);
`else
    ready_c = !(bus.in_valid && (haz_a || haz_b));
    opa     = regs[bus.rdest_sel];
    opb     = bus.imm_sel ? bus.imm : regs[bus.rsrc_sel];
`endif
  end

  assign accept = bus.in_valid && ready_c;

  // E stage: operand and control capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e <= '0;
    end else begin
      e.valid <= accept;
      if (accept) begin
        e.op   <= bus.opcode;
        e.dest <= bus.rdest_sel;
        e.wb   <= bus.wb_en;
        e.a    <= opa;
        e.b    <= opb;
      end
    end
  end

  // W stage: result/flags registers and register-file writeback
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i] <= '0;
      end
    end else begin
      out_valid_q <= e.valid;
      if (e.valid) begin
        result_q <= res;
        flags_q  <= flags_nxt;
        if (e_writes) begin
          regs[e.dest] <= res;
        end
      end
    end
  end

  assign bus.in_ready   = ready_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.alu_result = result_q;
  assign bus.flags      = flags_q;
  assign bus.dbg_data   = regs[bus.dbg_sel];

endmodule

// File: tb/tb_regfile_alu_pipe.sv
// tb_regfile_alu_pipe: randomized and directed stimulus for regfile_alu_pipe, checked every
// cycle against a sequential-semantics model (each accepted op executes in program order
// on an architectural register file; its result shows up one cycle later).
module tb_regfile_alu_pipe;

  localparam int unsigned W   = 16;
  localparam int unsigned NR  = 16;
  localparam int unsigned AWB = 4;
  localparam longint      MOD = 65536;

`ifdef RF_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_alu_pipe_if #(.WIDTH(W), .AW(AWB)) bus ();

  regfile_alu_pipe #(.WIDTH(W), .NUM_REGS(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // Architectural state after all accepted ops (spec_*) and after retired ops (com_*)
  int unsigned spec_regs [NR];
  int unsigned com_regs  [NR];
  logic [4:0]  spec_flags;
  logic [4:0]  com_flags;
  // Op accepted on the last edge, retiring on the next one
  logic        e_pend;
  logic        e_wr;
  logic [3:0]  e_dest;
  int unsigned e_res;
  logic [4:0]  e_flags;
  // Output expectation for the current cycle
  logic        exp_ov;
  int unsigned exp_res;
  // Last observed DUT values for the directed literal checks
  logic [W-1:0] last_res;
  logic [W-1:0] last_dbg;
  logic [4:0]   last_flags;
  int           ov_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sgn(input int unsigned v);
    return (v >= 32768) ? longint'(v) - MOD : longint'(v);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < int'(NR); i++) begin
      spec_regs[i] = 0;
      com_regs[i]  = 0;
    end
    spec_flags = '0;
    com_flags  = '0;
    e_pend     = 1'b0;
    e_wr       = 1'b0;
    e_dest     = '0;
    e_res      = 0;
    e_flags    = '0;
    exp_ov     = 1'b0;
    exp_res    = 0;
  endfunction

  // Plain-arithmetic reference for one op; fl is the flag state before/after
  task automatic model_exec(input logic [3:0] op, input int unsigned a, input int unsigned b,
                            output int unsigned r, output logic writes, inout logic [4:0] fl);
    longint sa;
    longint sb;
    longint t;
    sa     = sgn(a);
    sb     = sgn(b);
    r      = 0;
    writes = 1'b1;
    case (op)
      4'd1: begin
        t  = longint'(a) + longint'(b);
        r  = 32'(t % MOD);
        fl = {r >= 32'd32768, r == 0, (sa + sb > 32767) || (sa + sb < -32768), 1'b0, t >= MOD};
      end
      4'd2, 4'd3: begin
        r      = 32'((longint'(a) - longint'(b) + MOD) % MOD);
        fl     = {sa < sb, r == 0, (sa - sb > 32767) || (sa - sb < -32768), a < b, a < b};
        writes = (op == 4'd2);
      end
      4'd4: r = a & b;
      4'd5: r = a | b;
      4'd6: r = a ^ b;
      4'd7: r = b;
      4'd8: r = 32'((longint'(a) << (b % W)) % MOD);
      4'd9: r = a >> (b % W);
      default: begin
        r      = 0;
        writes = 1'b0;
      end
    endcase
  endtask

  function automatic logic model_ready(input logic v, input logic [3:0] rd,
                                       input logic [3:0] rs, input logic is);
    return FWD || !(v && e_pend && e_wr && (rd == e_dest || (!is && rs == e_dest)));
  endfunction

  // Advance the model across one rising edge
  task automatic model_edge(input logic acc, input logic [3:0] op, input logic [3:0] rd,
                            input logic [3:0] rs, input logic [15:0] im, input logic is,
                            input logic wb);
    int unsigned a;
    int unsigned b;
    int unsigned r;
    logic        wrt;
    exp_ov = e_pend;
    if (e_pend) begin
      exp_res   = e_res;
      com_flags = e_flags;
      if (e_wr) com_regs[e_dest] = e_res;
    end
    e_pend = acc;
    if (acc) begin
      a = spec_regs[rd];
      b = is ? 32'(im) : spec_regs[rs];
      model_exec(op, a, b, r, wrt, spec_flags);
      e_wr    = wrt && wb;
      e_res   = r;
      e_flags = spec_flags;
      e_dest  = rd;
      if (e_wr) spec_regs[rd] = r;
    end
  endtask

  // Compare every DUT output against the model for the current cycle
  task automatic compare(input logic v, input logic [3:0] rd, input logic [3:0] rs,
                         input logic is, input logic [3:0] ds);
    chk("in_ready", 32'(bus.in_ready), 32'(model_ready(v, rd, rs, is)));
    chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
    if (exp_ov) chk("alu_result", 32'(bus.alu_result), exp_res);
    chk("flags", 32'(bus.flags), 32'(com_flags));
    chk("dbg_data", 32'(bus.dbg_data), com_regs[ds]);
    if (bus.out_valid === 1'b1) begin
      ov_seen++;
      last_res   = bus.alu_result;
      last_flags = bus.flags;
    end
    last_dbg = bus.dbg_data;
  endtask

  // One clock: drive at negedge, check, then let the model follow the rising edge
  task automatic step(input logic v, input logic [3:0] op, input logic [3:0] rd,
                      input logic [3:0] rs, input logic [15:0] im, input logic is,
                      input logic wb, input logic [3:0] ds, output logic acc);
    @(negedge clk);
    bus.in_valid  = v;
    bus.opcode    = op;
    bus.rdest_sel = rd;
    bus.rsrc_sel  = rs;
    bus.imm       = im;
    bus.imm_sel   = is;
    bus.wb_en     = wb;
    bus.dbg_sel   = ds;
    #1;
    compare(v, rd, rs, is, ds);
    acc = v && (bus.in_ready === 1'b1);
    @(posedge clk);
    model_edge(acc, op, rd, rs, im, is, wb);
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                       input logic [15:0] im, input logic is, input logic wb,
                       output int stalls);
    logic acc;
    acc    = 1'b0;
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, op, rd, rs, im, is, wb, rd, acc);
      if (acc) break;
      stalls++;
    end
    chk("issue_accepted", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int n, input logic [3:0] ds);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 4'd0, 4'd0, 16'h0, 1'b0, 1'b0, ds, acc);
  endtask

  // Reset with an op presented, spanning one rising edge
  task automatic reset_pulse();
    @(negedge clk);
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.opcode    = 4'd7;
    bus.rdest_sel = 4'd6;
    bus.imm       = 16'hBEEF;
    bus.imm_sel   = 1'b1;
    bus.wb_en     = 1'b1;
    model_reset();
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_hold_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_hold_dbg6", 32'(bus.dbg_data), 32'd0);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          st;
    logic        acc;
    logic        v;
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [15:0] im;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.opcode    = '0;
    bus.rdest_sel = '0;
    bus.rsrc_sel  = '0;
    bus.imm       = '0;
    bus.imm_sel   = 1'b0;
    bus.wb_en     = 1'b0;
    bus.dbg_sel   = '0;
    ov_seen       = 0;
    model_reset();
    repeat (2) @(posedge clk);
    reset_pulse();

    // Post-reset sweep
    for (int i = 0; i < int'(NR); i++) begin
      idle(1, 4'(i));
      chk("rst_sweep_dbg", 32'(last_dbg), 32'd0);
    end
    chk("rst_flags", 32'(bus.flags), 32'd0);
    chk("rst_ov_count", 32'(ov_seen), 32'd0);

    // MOV R1,#7FFF ; ADD R1,#1 -> signed overflow
    issue(4'd7, 4'd1, 4'd0, 16'h7FFF, 1'b1, 1'b1, st);
    issue(4'd1, 4'd1, 4'd0, 16'h0001, 1'b1, 1'b1, st);
    idle(2, 4'd1);
    chk("add_ovf_res", 32'(last_res), 32'h8000);
    chk("add_ovf_flags", 32'(last_flags), 32'h14);
    chk("add_ovf_r1", 32'(last_dbg), 32'h8000);

    // MOV R2,#5 ; CMP R2,#9 (wb set, must not write) ; AND keeps flags
    issue(4'd7, 4'd2, 4'd0, 16'h0005, 1'b1, 1'b1, st);
    issue(4'd3, 4'd2, 4'd0, 16'h0009, 1'b1, 1'b1, st);
    idle(2, 4'd2);
    chk("cmp_res", 32'(last_res), 32'hFFFC);
    chk("cmp_flags", 32'(last_flags), 32'h13);
    chk("cmp_r2_kept", 32'(last_dbg), 32'h5);
    issue(4'd4, 4'd2, 4'd0, 16'h00FF, 1'b1, 1'b1, st);
    idle(2, 4'd2);
    chk("and_res", 32'(last_res), 32'h5);
    chk("and_flags_held", 32'(last_flags), 32'h13);

    // Back-to-back dependency MOV R3,#3 ; ADD R3,R3
    issue(4'd7, 4'd3, 4'd0, 16'h0003, 1'b1, 1'b1, st);
    issue(4'd1, 4'd3, 4'd3, 16'h0000, 1'b0, 1'b1, st);
    chk("raw_stalls", 32'(st), FWD ? 32'd0 : 32'd1);
    idle(2, 4'd3);
    chk("raw_res", 32'(last_res), 32'h6);
    chk("raw_r3", 32'(last_dbg), 32'h6);

    // ADD wrap to zero, then shift amount taken modulo width
    issue(4'd7, 4'd4, 4'd0, 16'h0001, 1'b1, 1'b1, st);
    issue(4'd1, 4'd4, 4'd0, 16'hFFFF, 1'b1, 1'b1, st);
    idle(2, 4'd4);
    chk("add_wrap_res", 32'(last_res), 32'h0);
    chk("add_wrap_flags", 32'(last_flags), 32'h09);
    issue(4'd7, 4'd4, 4'd0, 16'h0003, 1'b1, 1'b1, st);
    issue(4'd8, 4'd4, 4'd0, 16'd17, 1'b1, 1'b1, st);
    idle(2, 4'd4);
    chk("lsh17_res", 32'(last_res), 32'h6);
    chk("lsh17_flags_held", 32'(last_flags), 32'h09);

    // Reset between accept and writeback discards the op
    issue(4'd7, 4'd6, 4'd0, 16'h1234, 1'b1, 1'b1, st);
    ov_seen = 0;
    reset_pulse();
    idle(3, 4'd6);
    chk("midrst_no_pulse", 32'(ov_seen), 32'd0);
    chk("midrst_r6", 32'(last_dbg), 32'd0);

    // Randomized traffic biased toward few registers for frequent hazards
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) reset_pulse();
      v  = ($urandom_range(0, 3) != 0);
      op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      rd = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      rs = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0:       im = 16'h0000;
        1:       im = 16'hFFFF;
        2:       im = 16'h7FFF;
        3:       im = 16'h8000;
        default: im = 16'($urandom());
      endcase
      step(v, op, rd, rs, im, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0),
           4'($urandom_range(0, 15)), acc);
    end
    idle(2, 4'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
